// File: rtl/dlx_pkg.sv
// dlx_pkg: shared hazard controller types and constants for the DLX core
package dlx_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/dep_match.sv
// dep_match: flags an ID-stage source that depends on a pending load in a later stage
module dep_match
    import dlx_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rd,
    input  logic       load,
    output logic       hit
);
    assign hit = load && rd != REG_ZERO && ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: DLX pipeline stall/bubble/flush control with memory-timeout FSM; PIPE_PERF_EN adds perf counters
module hazard_ctrl
    import dlx_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             load_EX,
    input  logic [4:0]       rd_MEM,
    input  logic             load_MEM,
    input  logic             pc_cmd_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             bubble_EX,
    output logic             flush_ID,
    output logic             mem_error,
    output logic [1:0]       state_o
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] load_use_cnt
`endif
);
    localparam logic [15:0] LAST = 16'(MEM_TIMEOUT - 1);

    hazard_state_t state, state_nx;
    logic [15:0] wait_cnt;
    logic        freeze, hit_ex, hit_mem, load_use, timeout;

    dep_match u_dep_ex (
        .rs1(rs1_ID), .rs2(rs2_ID), .use_rs1(use_rs1_ID), .use_rs2(use_rs2_ID),
        .rd(rd_EX), .load(load_EX), .hit(hit_ex)
    );
    dep_match u_dep_mem (
        .rs1(rs1_ID), .rs2(rs2_ID), .use_rs1(use_rs1_ID), .use_rs2(use_rs2_ID),
        .rd(rd_MEM), .load(load_MEM), .hit(hit_mem)
    );

    assign freeze    = dmem_req_MEM && !dmem_ready;
    assign load_use  = hit_ex || hit_mem;
    // wait_cnt holds the frozen cycles before this one, so this is the MEM_TIMEOUT-th
    assign timeout   = freeze && wait_cnt == LAST;
    assign mem_error = state == ERROR;
    assign state_o   = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (freeze && state != ERROR) ? wait_cnt + 16'(wait_cnt != 16'hffff) : '0;
        end
    end

    always_comb begin
        state_nx  = (state == ERROR || timeout) ? ERROR : freeze ? MEM_WAIT : RUN;
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        stall_EX  = 1'b0;
        stall_MEM = 1'b0;
        bubble_EX = 1'b0;
        flush_ID  = 1'b0;
        if (state == ERROR || freeze) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            stall_EX  = 1'b1;
            stall_MEM = 1'b1;
        end else if (pc_cmd_EX) begin
            flush_ID  = 1'b1;
            bubble_EX = 1'b1;
        end else if (load_use) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            bubble_EX = 1'b1;
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_cnt    <= '0;
            load_use_cnt <= '0;
        end else begin
            stall_cycles <= stall_cycles + CNT_W'(stall_IF && stall_cycles != '1);
            flush_cnt    <= flush_cnt + CNT_W'(flush_ID && flush_cnt != '1);
            load_use_cnt <= load_use_cnt + CNT_W'(bubble_EX && !flush_ID && load_use_cnt != '1);
        end
    end
`endif
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage DLX core. It watches register indices in ID, load/destination info in EX and MEM, the taken-branch command from EX, and the data-memory handshake in MEM. From these it drives per-stage stall, bubble and flush controls. A small FSM tracks data-memory wait states and raises a sticky error on a memory timeout; optional performance counters are provided.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive wait cycles in MEM before error (1..65535).
- CNT_W, 32: width of performance counters.

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- rs1_ID, rs2_ID  in  5 each  source register indices of instruction in ID
- use_rs1_ID, use_rs2_ID  in  1 each  instruction in ID reads that source
- rd_EX  in  5  destination of instruction in EX
- load_EX  in  1  instruction in EX is a load
- rd_MEM  in  5  destination of instruction in MEM
- load_MEM  in  1  instruction in MEM is a load
- pc_cmd_EX  in  1  taken branch/jump resolved in EX
- dmem_req_MEM  in  1  load or store active in MEM
- dmem_ready  in  1  data memory completes access this cycle
- stall_IF  out  1  hold PC and IF/ID
- stall_ID  out  1  hold ID/EX
- stall_EX  out  1  hold EX/MEM
- stall_MEM  out  1  hold MEM/WB
- bubble_EX  out  1  load NOP into ID/EX (all enables 0, Rd 0)
- flush_ID  out  1  replace IF/ID contents with NOP
- mem_error  out  1  sticky memory-timeout flag
- state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR
- stall_cycles, flush_cnt, load_use_cnt  out  CNT_W each  perf counters (PIPE_PERF_EN only)

## Operation
- freeze = dmem_req_MEM & !dmem_ready.
- load_use = match on rd_EX with load_EX, or match on rd_MEM with load_MEM.
  - A match means rd≠0 and ((use_rs1_ID & rs1_ID==rd) | (use_rs2_ID & rs2_ID==rd)).
  - MEM-stage forwarding carries the ALU result, not load data, so a load in MEM also blocks. A dependent load therefore costs 2 stall cycles.
- Priority, evaluated combinationally each cycle:
  - ERROR state: all four stalls = 1, bubble_EX = 0, flush_ID = 0.
  - freeze: all four stalls = 1, bubble_EX = 0, flush_ID = 0. A branch or load-use condition is held and re-evaluated when freeze drops.
  - pc_cmd_EX: flush_ID = 1, bubble_EX = 1, all stalls = 0. The branch wins over load-use because the ID instruction is discarded.
  - load_use: stall_IF = stall_ID = 1, bubble_EX = 1, stall_EX = stall_MEM = 0.
  - Otherwise all outputs are 0.
- FSM:
  - RUN -> MEM_WAIT on freeze.
  - MEM_WAIT -> RUN on dmem_ready, or when dmem_req_MEM drops.
  - MEM_WAIT -> ERROR when wait_cnt == MEM_TIMEOUT-1 and freeze is still high.
  - ERROR is left only by reset.
- wait_cnt (16 bit):
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle with freeze high.
  - Never wraps.
- mem_error = (state == ERROR).

## Timing
- All control outputs are combinational from the current inputs and registered state, so they are valid in the same cycle. Zero latency.
- dmem_ready seen in the first request cycle: no freeze, no state change.
- A wait of N cycles (ready on cycle N+1): freeze is asserted for N cycles. state_o = 1 from the 2nd through the (N+1)th cycle.
- Timeout: ERROR is entered at the edge after MEM_TIMEOUT consecutive frozen cycles. state_o = 2 and mem_error = 1 from the next cycle onward.
- Reset (any state, including mid-wait):
  - State goes to RUN; wait_cnt and all counters go to 0; mem_error = 0.
  - Combinational outputs follow their inputs from the first cycle after reset.

## Configuration
- PIPE_PERF_EN defined, counters exist; each saturates at all-ones:
  - stall_cycles increments on every cycle with stall_IF = 1.
  - flush_cnt increments on every cycle with flush_ID = 1.
  - load_use_cnt increments on every load-use bubble.
- PIPE_PERF_EN undefined: counter ports and logic are removed.

## Structure
- dlx_pkg:
  - hazard_state_t enum (RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2).
  - REG_ZERO = 5'd0.
- Sub-module dep_match: one instance per source stage (EX, MEM). It computes the rs/rd match; instantiated twice.

## Test plan
- rd_EX = 5, load_EX = 1, rs1_ID = 5, use_rs1_ID = 1 -> stall_IF = stall_ID = bubble_EX = 1 for 1 cycle. Next cycle rd_MEM = 5, load_MEM = 1 -> 1 more stall. The third cycle is clear.
- Same as above with rd_EX = 0 -> no stall. With load_EX = 0 (ALU op) -> no stall, because forwarding covers it.
- pc_cmd_EX = 1 together with a load-use match -> flush_ID = 1, bubble_EX = 1, stall_IF = 0; flush_cnt += 1.
- dmem_req_MEM = 1, dmem_ready low for 3 cycles then high:
  - All stalls = 1 for 3 cycles, state_o = 1 on cycles 2-4.
  - Then RUN; stall_cycles = 3.
- MEM_TIMEOUT = 4, ready held low:
  - ERROR entered after 4 frozen cycles; mem_error = 1 stays high while ready goes high.
  - reset_n = 0 for 1 cycle -> state_o = 0, mem_error = 0.
- pc_cmd_EX = 1 during freeze -> flush_ID = 0 while frozen. flush_ID = 1 on the cycle dmem_ready rises.
